// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: writes one palette index per cycle over a clipped
// rectangle of a row-major framebuffer (address = y*H_RES + x).
module rect_fill_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        procClock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [7:0]  cmd_index,
  input  logic        abort,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] HRES11 = 11'(H_RES);
  localparam logic [9:0]  VRES10 = 10'(V_RES);
  localparam logic [18:0] PITCH  = 19'(H_RES);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, w_q;
  logic [8:0]  y_q, h_q;
  logic [7:0]  idx_q;
  logic [10:0] xend_q;
  logic [9:0]  yend_q;
  logic [9:0]  col_q;
  logic [8:0]  row_q;
  logic [18:0] rowstart_q;
  logic [18:0] addr_q;
  logic [7:0]  data_q;

  logic [10:0] x_sum, x_end;
  logic [9:0]  y_sum, y_end;
  logic        empty;
  logic [18:0] row_base;
  logic        last_col, last_row, accept;

  // Clipping on sums one bit wider than the operands so nothing wraps.
  always_comb begin
    x_sum = {1'b0, x_q} + {1'b0, w_q};
    y_sum = {1'b0, y_q} + {1'b0, h_q};
    x_end = (x_sum > HRES11) ? HRES11 : x_sum;
    y_end = (y_sum > VRES10) ? VRES10 : y_sum;
    empty = (w_q == 10'd0) || (h_q == 9'd0) ||
            ({1'b0, x_q} >= HRES11) || ({1'b0, y_q} >= VRES10);
  end

  // Row base is formed once per command; the per-pixel path only adds.
  generate
    if (H_RES == 640) begin : g_rb640
      assign row_base = ({10'd0, y_q} << 9) + ({10'd0, y_q} << 7);
    end else begin : g_rbgen
      assign row_base = 19'({10'd0, y_q} * PITCH);
    end
  endgenerate

  assign last_col = (({1'b0, col_q} + 11'd1) == xend_q);
  assign last_row = (({1'b0, row_q} + 10'd1) == yend_q);
  assign accept   = (state_q == IDLE) && cmd_valid;

  // State register.
  always_ff @(posedge procClock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: state_d = empty ? DONE : FILL;
      FILL: begin
        wr_en = 1'b1;
        if (abort || (last_col && last_row)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, setup of clip bounds and the pixel walk.
  always_ff @(posedge procClock or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      idx_q      <= '0;
      xend_q     <= '0;
      yend_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rowstart_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      if (accept) begin
        x_q   <= cmd_x;
        y_q   <= cmd_y;
        w_q   <= cmd_w;
        h_q   <= cmd_h;
        idx_q <= cmd_index;
      end
      // Address/data only move when a fill will follow, so they stay quiet
      // across empty commands.
      if (state_q == SETUP && !empty) begin
        xend_q     <= x_end;
        yend_q     <= y_end;
        col_q      <= x_q;
        row_q      <= y_q;
        rowstart_q <= row_base + {9'd0, x_q};
        addr_q     <= row_base + {9'd0, x_q};
        data_q     <= idx_q;
      end
      if (state_q == FILL && !abort && !(last_col && last_row)) begin
        if (last_col) begin
          col_q      <= x_q;
          row_q      <= row_q + 9'd1;
          rowstart_q <= rowstart_q + PITCH;
          addr_q     <= rowstart_q + PITCH;
        end else begin
          col_q  <= col_q + 10'd1;
          addr_q <= addr_q + 19'd1;
        end
      end
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer with an expected-write scoreboard.
module tb_rect_fill_writer;
  localparam int H = 640;
  localparam int V = 480;

  logic        procClock = 1'b0;
  logic        reset     = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0;
  logic [8:0]  cmd_y = '0;
  logic [9:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [7:0]  cmd_index = '0;
  logic        abort = 1'b0;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en, busy, done;

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int nw     = 0;

  rect_fill_writer #(.H_RES(H), .V_RES(V)) dut (
    .procClock(procClock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_index(cmd_index), .abort(abort),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  always #5 procClock = ~procClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    exp_t e;
    e.a = 19'(a);
    e.d = 8'(d);
    q.push_back(e);
  endtask

  // Reference: plain nested loops over the clipped rectangle, y*640+x.
  task automatic push_model(input int x, input int y, input int w, input int h,
                            input int idx, input int limit, output int n);
    int xe, ye;
    xe = (x + w > H) ? H : x + w;
    ye = (y + h > V) ? V : y + h;
    n = 0;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        if (n < limit) begin
          push(yy * H + xx, idx);
          n++;
        end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, writes scored.
  task automatic cycle();
    exp_t e;
    @(posedge procClock);
    #1;
    if (wr_en) begin
      nw++;
      check("addr_in_frame", 32'(wr_addr < 19'(H * V)), 1);
      check("write_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  endtask

  task automatic junk();
    cmd_x     = 10'($urandom_range(0, 1023));
    cmd_y     = 9'($urandom_range(0, 511));
    cmd_w     = 10'($urandom_range(0, 1023));
    cmd_h     = 9'($urandom_range(0, 511));
    cmd_index = 8'($urandom_range(0, 255));
  endtask

  // Issue one command and follow it to completion. Expected writes come
  // from the model (use_model) or were pushed beforehand by the caller.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int idx, input int abort_at,
                         input bit keep_valid, input bit use_model);
    int n, lat;
    bit got;
    if (use_model) push_model(x, y, w, h, idx, (abort_at > 0) ? abort_at : 32'h3fffffff, n);
    else n = q.size();
    cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h);
    cmd_index = 8'(idx);
    cmd_valid = 1'b1;
    abort = 1'b0;
    nw = 0;
    cycle();
    check("accept_busy", 32'(busy), 1);
    check("accept_ready", 32'(cmd_ready), 0);
    if (keep_valid) junk(); else cmd_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < n + 50) begin
      abort = (abort_at > 0) && (nw == abort_at);
      cycle();
      lat++;
      if (keep_valid) junk();
      if (done) got = 1'b1;
    end
    abort = 1'b0;
    check("done_seen", 32'(got), 1);
    check("done_latency", lat, n + 2);
    check("write_count", nw, n);
    check("queue_empty", q.size(), 0);
    cycle();
    check("ready_after_done", 32'(cmd_ready), 1);
    check("busy_after_done", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int n;
    // Reset values before any clock edge.
    #3;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    #4 reset = 1'b0;

    // Small rectangle, addresses written out by hand.
    push(1290, 8'h57); push(1291, 8'h57); push(1292, 8'h57);
    push(1930, 8'h57); push(1931, 8'h57); push(1932, 8'h57);
    run_cmd(10, 2, 3, 2, 8'h57, 0, 1'b0, 1'b0);

    // Bottom-right corner, clipped to two pixels.
    push(307198, 8'hA5); push(307199, 8'hA5);
    run_cmd(638, 479, 25, 25, 8'hA5, 0, 1'b0, 1'b0);

    // Empty rectangles: zero size or fully off-screen.
    run_cmd(5, 5, 0, 4, 8'h01, 0, 1'b0, 1'b1);
    run_cmd(700, 10, 5, 5, 8'h02, 0, 1'b0, 1'b1);
    run_cmd(5, 5, 4, 0, 8'h03, 0, 1'b0, 1'b1);
    run_cmd(5, 480, 4, 4, 8'h04, 0, 1'b0, 1'b1);

    // Full frame aborted after 101 writes, then a normal command.
    run_cmd(0, 0, 640, 480, 8'h11, 101, 1'b0, 1'b1);
    run_cmd(100, 200, 3, 3, 8'h22, 0, 1'b0, 1'b1);

    // Assorted shapes including clipping on both edges.
    run_cmd(600, 470, 100, 20, 8'h3C, 0, 1'b0, 1'b1);
    run_cmd(639, 0, 1, 3, 8'h7E, 0, 1'b0, 1'b1);
    run_cmd(0, 0, 1, 1, 8'hFF, 0, 1'b0, 1'b1);

    // cmd_valid held high with fields changing every cycle.
    run_cmd(20, 30, 4, 3, 8'h44, 0, 1'b1, 1'b1);
    run_cmd(300, 100, 5, 2, 8'h55, 0, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    cycle();
    check("idle_after_held", 32'(busy), 0);

    // Reset in the middle of a fill.
    push_model(0, 0, 20, 5, 8'h33, 32'h3fffffff, n);
    cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd20; cmd_h = 9'd5;
    cmd_index = 8'h33;
    cmd_valid = 1'b1;
    nw = 0;
    cycle();
    cmd_valid = 1'b0;
    repeat (6) cycle();
    check("pre_reset_filling", 32'(wr_en), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    check("mid_rst_addr", 32'(wr_addr), 0);
    check("mid_rst_data", 32'(wr_data), 0);
    q.delete();
    cmd_valid = 1'b1;
    repeat (2) begin
      cycle();
      check("held_in_reset", 32'(busy), 0);
      check("no_done_after_rst", 32'(done), 0);
    end
    reset = 1'b0;
    run_cmd(5, 3, 4, 2, 8'h99, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill_writer.md
RECT_FILL_WRITER -- requirements
Module: rect_fill_writer

Interface
REQ-001 Parameter H_RES, default 640, frame width in pixels and row pitch of the framebuffer.
REQ-002 Parameter V_RES, default 480, frame height in pixels.
REQ-003 procClock  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_x  in  10  left column of the rectangle.
REQ-008 cmd_y  in  9  top row of the rectangle.
REQ-009 cmd_w  in  10  width in pixels.
REQ-010 cmd_h  in  9  height in pixels.
REQ-011 cmd_index  in  8  palette index to write.
REQ-012 abort  in  1  terminate the current fill.
REQ-013 wr_addr  out  19  framebuffer write address, row-major, y*H_RES+x.
REQ-014 wr_data  out  8  palette index written.
REQ-015 wr_en  out  1  write strobe, one pixel per asserted cycle.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on command completion.

Function
REQ-018 The states SHALL be IDLE, SETUP, FILL and DONE; cmd_ready SHALL be high only in IDLE.
REQ-019 A command SHALL be accepted on the edge where cmd_valid and cmd_ready are both high; all cmd_* fields SHALL be registered then, and later changes to the inputs SHALL have no effect.
REQ-020 IDLE->SETUP on accept; SETUP SHALL last exactly one cycle; SETUP->FILL for a non-empty clipped rectangle, otherwise SETUP->DONE.
REQ-021 Clipping: x_end=min(cmd_x+cmd_w, H_RES) using an 11-bit sum; y_end=min(cmd_y+cmd_h, V_RES) using a 10-bit sum; no overflow wrap is permitted.
REQ-022 The clipped rectangle is empty if cmd_w==0, cmd_h==0, cmd_x>=H_RES or cmd_y>=V_RES; an empty rectangle SHALL produce zero writes and still pulse done.
REQ-023 The row base SHALL be computed in SETUP as (y<<9)+(y<<7) when H_RES=640; a general multiplier SHALL NOT be placed in the per-pixel path.
REQ-024 In FILL, wr_en SHALL be high every cycle, one pixel per cycle, in row-major order, with no gaps; the first write occurs in the cycle after SETUP.
REQ-025 Within a row, wr_addr SHALL increment by 1; at row end it SHALL advance to the next row base + x_start, with no idle cycle.
REQ-026 wr_data SHALL equal the registered cmd_index whenever wr_en is high.
REQ-027 After the write at (x_end-1, y_end-1), the next state SHALL be DONE; total writes = (x_end-x)*(y_end-y).
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; cmd_ready SHALL be high the cycle after done.
REQ-029 abort sampled high in FILL: the write in that cycle still completes, wr_en is low from the next cycle, and the next state is DONE.
REQ-030 abort in IDLE, SETUP or DONE SHALL be ignored.
REQ-031 wr_addr SHALL never exceed H_RES*V_RES-1 while wr_en is high.
REQ-032 wr_addr and wr_data are don't-care while wr_en is low, but SHALL hold their last values (no toggling).

Reset
REQ-033 On reset assertion, asynchronously: state=IDLE, cmd_ready=1, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-034 Reset mid-FILL SHALL abandon the command with no done pulse; a new command SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-035 cmd (x=10, y=2, w=3, h=2, idx=0x57): exactly 6 writes at addresses 1290,1291,1292,1930,1931,1932 on consecutive cycles; done one cycle after the last write.
REQ-036 cmd (x=638, y=479, w=25, h=25): clipped to 2 writes at 307198 and 307199; no address >=307200 appears.
REQ-037 cmd with w=0, or with x=700: zero wr_en cycles; SETUP then done pulse; cmd_ready high 3 cycles after accept.
REQ-038 cmd (0, 0, 640, 480) with abort pulsed after 100 writes: exactly 101 writes total, then done; a following command is accepted normally.
REQ-039 Reset asserted during FILL: outputs return to reset values immediately, with no done pulse; cmd_valid held high is accepted on the first post-reset edge.
REQ-040 cmd_valid held high continuously with changing fields: only one command is accepted per IDLE visit, and each fill uses the fields captured at its handshake.
